// File: rtl/regfile_pkg.sv
// Shared types and default parameters for the multi-port register file.
// The top level and the scoreboard take their parameter defaults from here.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int AW_DEF     = $clog2(NREGS_DEF);
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 1;
    localparam int BYPASS_DEF = 1;

    localparam int ZERO_REG = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: alloc sets, writeback clears, alloc wins.
// Also provides the per-read-port busy lookup, cleared by a matching write when bypassing.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF,
    parameter int BYPASS = BYPASS_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_WR-1:0]           wen_i,
    input  logic [NUM_WR-1:0][AW-1:0]   waddr_i,
    input  logic [NUM_RD-1:0][AW-1:0]   raddr_i,
    input  logic                        alloc_i,
    input  logic [AW-1:0]               alloc_addr_i,
    output logic [NUM_RD-1:0]           rbusy_o,
    output logic [NREGS-1:0]            busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears applied first so a same-edge alloc overrides them.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wen_i[k]) begin
                busy_d[waddr_i[k]] = 1'b0;
            end
        end
        if (alloc_i) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rbusy_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rbusy_o[j] = busy_q[raddr_i[j]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wen_i[k] && (waddr_i[k] == raddr_i[j])) begin
                        rbusy_o[j] = 1'b0;
                    end
                end
            end
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass
// and a busy scoreboard; register 0 reads as zero and is never busy.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF,
    parameter int BYPASS = BYPASS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_WR-1:0]             wen_i,
    input  logic [NUM_WR-1:0][AW-1:0]     waddr_i,
    input  logic [NUM_WR-1:0][XLEN-1:0]   wdata_i,
    input  logic [NUM_RD-1:0][AW-1:0]     raddr_i,
    output logic [NUM_RD-1:0][XLEN-1:0]   rdata_o,
    output logic [NUM_RD-1:0]             rbusy_o,
    input  logic                          alloc_i,
    input  logic [AW-1:0]                 alloc_addr_i,
    output logic [NREGS-1:0]              busy_o
);

    logic [XLEN-1:0] regs [NREGS];

    // Later ports are assigned last, so the highest-index writer wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wen_i[k] && (waddr_i[k] != AW'(ZERO_REG))) begin
                    regs[waddr_i[k]] <= wdata_i[k];
                end
            end
        end
    end

    // Reset also masks bypassed write data, so every port reads 0 during reset.
    always_comb begin
        rdata_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (!rst_i && (raddr_i[j] != AW'(ZERO_REG))) begin
                rdata_o[j] = regs[raddr_i[j]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (wen_i[k] && (waddr_i[k] == raddr_i[j])) begin
                            rdata_o[j] = wdata_i[k];
                        end
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .AW     (AW),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wen_i        (wen_i),
        .waddr_i      (waddr_i),
        .raddr_i      (raddr_i),
        .alloc_i      (alloc_i),
        .alloc_addr_i (alloc_addr_i),
        .rbusy_o      (rbusy_o),
        .busy_o       (busy_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus
// and are compared against a behavioural model, directed vectors and random traffic.
module tb_regfile_mp;

    logic                 clk;
    logic                 rst;
    logic [1:0]           wen;
    logic [1:0][4:0]      waddr;
    logic [1:0][31:0]     wdata;
    logic [3:0][4:0]      raddr;
    logic                 alloc;
    logic [4:0]           alloc_addr;
    logic [3:0][31:0]     rdata_b, rdata_n;
    logic [3:0]           rbusy_b, rbusy_n;
    logic [31:0]          busy_b, busy_n;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];
    logic [31:0] mbusy;

    regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(4), .NUM_WR(2), .BYPASS(1)) u_byp (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .alloc_i(alloc), .alloc_addr_i(alloc_addr), .busy_o(busy_b)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(4), .NUM_WR(2), .BYPASS(0)) u_nob (
        .clk_i(clk), .rst_i(rst), .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
        .alloc_i(alloc), .alloc_addr_i(alloc_addr), .busy_o(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [1:0]       wen;
        logic [4:0]       wa0, wa1;
        logic [31:0]      wd0, wd1;
        logic [3:0][4:0]  ra;
        logic             alloc;
        logic [4:0]       aa;
        logic [31:0]      exp_b;
        logic [31:0]      exp_n;
        logic             exp_rb;
        logic [31:0]      exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) mem[r] = '0;
        mbusy = '0;
    endtask

    function automatic logic [31:0] exp_rd(input int j, input bit byp);
        logic [31:0] v;
        if (rst || raddr[j] == 5'd0) return 32'h0;
        v = mem[raddr[j]];
        if (byp)
            for (int k = 0; k < 2; k++)
                if (wen[k] && waddr[k] == raddr[j]) v = wdata[k];
        return v;
    endfunction

    function automatic logic exp_rbusy(input int j, input bit byp);
        logic v;
        if (rst) return 1'b0;
        v = mbusy[raddr[j]];
        if (byp)
            for (int k = 0; k < 2; k++)
                if (wen[k] && waddr[k] == raddr[j]) v = 1'b0;
        return v;
    endfunction

    task automatic model_edge();
        logic [31:0] nb;
        if (rst) begin
            model_clear();
            return;
        end
        nb = '0;
        for (int r = 1; r < 32; r++) begin
            bit set, clr;
            set = alloc && (alloc_addr == 5'(r));
            clr = 1'b0;
            for (int k = 0; k < 2; k++)
                if (wen[k] && waddr[k] == 5'(r)) clr = 1'b1;
            nb[r] = set ? 1'b1 : (clr ? 1'b0 : mbusy[r]);
        end
        mbusy = nb;
        for (int k = 0; k < 2; k++)
            if (wen[k] && waddr[k] != 5'd0) mem[waddr[k]] = wdata[k];
    endtask

    task automatic check_all();
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("model.rd_byp[%0d]", j), rdata_b[j], exp_rd(j, 1'b1));
            chk($sformatf("model.rd_nob[%0d]", j), rdata_n[j], exp_rd(j, 1'b0));
            chk($sformatf("model.rbusy_byp[%0d]", j), 32'(rbusy_b[j]), 32'(exp_rbusy(j, 1'b1)));
            chk($sformatf("model.rbusy_nob[%0d]", j), 32'(rbusy_n[j]), 32'(exp_rbusy(j, 1'b0)));
        end
        chk("model.busy_byp", busy_b, mbusy);
        chk("model.busy_nob", busy_n, mbusy);
    endtask

    task automatic idle_inputs();
        wen = '0; waddr = '0; wdata = '0; alloc = 1'b0; alloc_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        raddr = {5'd0, 5'd0, 5'd2, 5'd1};
        model_clear();

        // reset state
        #1;
        check_all();
        chk("reset.busy", busy_b, 32'h0);
        chk("reset.rd0", rdata_b[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        //          name           wen    wa0  wa1  wd0            wd1           ra {p3,p2,p1,p0}                alloc aa   exp_b          exp_n          rb    busy
        vecs.push_back('{"wr_r1",     2'b01, 5'd1, 5'd0, 32'hDEADBEEF, 32'h0,        {5'd0, 5'd0, 5'd2, 5'd1},     1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 32'h0});
        vecs.push_back('{"rd_r1",     2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        {5'd0, 5'd0, 5'd2, 5'd1},     1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{"zero_wr",   2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, {5'd0, 5'd0, 5'd0, 5'd0},     1'b1, 5'd0, 32'h0,        32'h0,        1'b0, 32'h0});
        vecs.push_back('{"conf_r5",   2'b11, 5'd5, 5'd5, 32'h1111,     32'h2222,     {5'd0, 5'd0, 5'd0, 5'd5},     1'b0, 5'd0, 32'h2222,     32'h0,        1'b0, 32'h0});
        vecs.push_back('{"after_r5",  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        {5'd0, 5'd0, 5'd0, 5'd5},     1'b0, 5'd0, 32'h2222,     32'h2222,     1'b0, 32'h0});
        vecs.push_back('{"alloc_r7",  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        {5'd0, 5'd0, 5'd0, 5'd7},     1'b1, 5'd7, 32'h0,        32'h0,        1'b0, 32'h80});
        vecs.push_back('{"busy_r7",   2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        {5'd0, 5'd0, 5'd0, 5'd7},     1'b0, 5'd0, 32'h0,        32'h0,        1'b1, 32'h80});
        vecs.push_back('{"wb_r7",     2'b01, 5'd7, 5'd0, 32'hCAFE,     32'h0,        {5'd0, 5'd0, 5'd0, 5'd7},     1'b0, 5'd0, 32'hCAFE,     32'h0,        1'b0, 32'h0});
        vecs.push_back('{"alloc_r9",  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        {5'd0, 5'd0, 5'd0, 5'd9},     1'b1, 5'd9, 32'h0,        32'h0,        1'b0, 32'h200});
        vecs.push_back('{"coll_r9",   2'b10, 5'd0, 5'd9, 32'h0,        32'hABCD,     {5'd0, 5'd0, 5'd0, 5'd9},     1'b1, 5'd9, 32'hABCD,     32'h0,        1'b0, 32'h200});
        vecs.push_back('{"after_r9",  2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        {5'd0, 5'd0, 5'd0, 5'd9},     1'b0, 5'd0, 32'hABCD,     32'hABCD,     1'b1, 32'h200});
        vecs.push_back('{"mp_wr",     2'b11, 5'd3, 5'd4, 32'h3,        32'h4,        {5'd31, 5'd0, 5'd4, 5'd3},    1'b0, 5'd0, 32'h3,        32'h0,        1'b0, 32'h200});
        vecs.push_back('{"mp_rd",     2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        {5'd31, 5'd0, 5'd4, 5'd3},    1'b0, 5'd0, 32'h3,        32'h3,        1'b0, 32'h200});

        foreach (vecs[i]) begin
            wen = vecs[i].wen;
            waddr = {vecs[i].wa1, vecs[i].wa0};
            wdata = {vecs[i].wd1, vecs[i].wd0};
            raddr = vecs[i].ra;
            alloc = vecs[i].alloc;
            alloc_addr = vecs[i].aa;
            #1;
            check_all();
            chk({vecs[i].name, ".rd_byp"}, rdata_b[0], vecs[i].exp_b);
            chk({vecs[i].name, ".rd_nob"}, rdata_n[0], vecs[i].exp_n);
            chk({vecs[i].name, ".rbusy_byp"}, 32'(rbusy_b[0]), 32'(vecs[i].exp_rb));
            @(posedge clk);
            model_edge();
            #1;
            chk({vecs[i].name, ".busy_after"}, busy_b, vecs[i].exp_busy);
        end

        // multi-port reads after the simultaneous r3/r4 writes
        idle_inputs();
        #1;
        chk("mp.p0", rdata_n[0], 32'h3);
        chk("mp.p1", rdata_n[1], 32'h4);
        chk("mp.p2", rdata_n[2], 32'h0);
        chk("mp.p3", rdata_n[3], 32'h0);

        // async reset between edges clears storage and scoreboard immediately
        raddr = {5'd9, 5'd0, 5'd0, 5'd1};
        #2;
        chk("async.pre_r1", rdata_b[0], 32'hDEADBEEF);
        rst = 1'b1;
        model_clear();
        #1;
        chk("async.r1_byp", rdata_b[0], 32'h0);
        chk("async.r1_nob", rdata_n[0], 32'h0);
        chk("async.busy", busy_b, 32'h0);
        wen = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'h0, 32'h1234}; alloc = 1'b1; alloc_addr = 5'd2;
        raddr = {5'd9, 5'd0, 5'd0, 5'd2};
        #1;
        chk("async.rd_during_rst", rdata_b[0], 32'h0);
        @(posedge clk);
        model_edge();
        #1;
        chk("async.busy_held", busy_n, 32'h0);
        idle_inputs();
        rst = 1'b0;
        #1;
        check_all();
        chk("async.r2_ignored", rdata_n[0], 32'h0);
        @(posedge clk); model_edge(); #1;

        // random traffic with small address range to provoke conflicts
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (rst) model_clear();
            wen = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                waddr[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                wdata[k] = $urandom;
            end
            for (int j = 0; j < 4; j++)
                raddr[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            alloc = ($urandom_range(0, 2) == 0);
            alloc_addr = 5'($urandom_range(0, 7));
            #1;
            check_all();
            @(posedge clk);
            model_edge();
            #1;
        end

        rst = 1'b0;
        idle_inputs();
        #1;
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
